run_step_ctrl: RTL and testbench

RUN_STEP_CTRL -- requirements
Module: run_step_ctrl

---
 rtl/run_step_ctrl_if.sv | 12 +
 rtl/run_step_ctrl.sv | 61 ++++++
 tb/tb_run_step_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/run_step_ctrl_if.sv
// run_step_ctrl_if: tick, button, halt and CPU-advance signals of the run/step controller.
interface run_step_ctrl_if;
  logic        tick_i;
  logic        btn_run;
  logic        btn_step;
  logic        halt_i;
  logic        cpu_en;
  logic [1:0]  state_o;
  logic [15:0] count_o;
  modport master (output tick_i, btn_run, btn_step, halt_i, input cpu_en, state_o, count_o);
  modport slave (input tick_i, btn_run, btn_step, halt_i, output cpu_en, state_o, count_o);
endinterface

// File: rtl/run_step_ctrl.sv
// run_step_ctrl: debounced run/step buttons gate a synchronized tick into one-cycle CPU advance pulses.
module run_step_ctrl #(
  parameter int DB_COUNT = 16
) (
  input  logic           clk_i,
  input  logic           rst,
  run_step_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, HALTED = 2'b11} state_t;
  state_t          state_q, state_d;
  logic [2:0]      tick_s;
  logic [1:0][1:0] b_s;
  logic [1:0][7:0] cnt;
  logic [1:0]      db, db_q, arm, raw, press, live;
  logic            tick_rise, en_d;
  assign raw       = {bus.btn_step, bus.btn_run};
  assign tick_rise = tick_s[1] & ~tick_s[2];
  // arm stays low until a settled released level is seen, so a button held across reset never presses
  assign press     = db & ~db_q & arm;
  assign en_d      = tick_rise & ~bus.halt_i & (state_q == RUN || state_q == STEP);
  always_ff @(posedge clk_i) begin
    if (rst) begin
      tick_s <= '0;
      b_s    <= '0;
      cnt    <= '0;
      db     <= '0;
      db_q   <= '0;
      arm    <= '0;
      live   <= '0;
    end else begin
      tick_s <= {tick_s[1:0], bus.tick_i};
      live   <= {live[0], 1'b1};
      db_q   <= db;
      for (int i = 0; i < 2; i++) begin
        b_s[i] <= {b_s[i][0], raw[i]};
        cnt[i] <= (b_s[i][1] != db[i] && cnt[i] != 8'(DB_COUNT - 1)) ? cnt[i] + 8'd1 : 8'd0;
        if (b_s[i][1] != db[i] && cnt[i] == 8'(DB_COUNT - 1)) db[i] <= ~db[i];
        if (live[1] && !b_s[i][1] && !db[i]) arm[i] <= 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    if (bus.halt_i) state_d = HALTED;
    else if (state_q == IDLE) state_d = press[0] ? RUN : press[1] ? STEP : IDLE;
    else if (state_q == RUN && press[0]) state_d = IDLE;
    else if (state_q == STEP && tick_rise) state_d = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q     <= IDLE;
      bus.cpu_en  <= 1'b0;
      bus.count_o <= '0;
    end else begin
      state_q    <= state_d;
      bus.cpu_en <= en_d;
      if (en_d) bus.count_o <= bus.count_o + 16'd1;
    end
  end
  assign bus.state_o = state_q;
endmodule

// File: tb/tb_run_step_ctrl.sv
// tb_run_step_ctrl: table-driven and directed checks of run_step_ctrl with a pulse scoreboard.
module tb_run_step_ctrl;
  logic clk_i = 0;
  logic rst = 1;
  run_step_ctrl_if rs();
  run_step_ctrl #(.DB_COUNT(4)) dut (.clk_i(clk_i), .rst(rst), .bus(rs));
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic       run;
    logic       step;
    logic       halt;
    logic [1:0] exp_state;
    int         exp_pulses;
  } vec_t;
  vec_t        vecs[6];
  int          n_cmp = 0, n_bad = 0, pulses = 0;
  logic [15:0] model_cnt = 0;
  logic [15:0] q[$];
  logic        prev_en = 0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask
  task automatic do_reset();
    check("missing_cpu_en", q.size(), 0);
    q.delete();
    rs.tick_i = 0; rs.btn_run = 0; rs.btn_step = 0; rs.halt_i = 0;
    rst = 1;
    cyc(2);
    @(negedge clk_i);
    check("rst_state", rs.state_o, 0);
    check("rst_cpu_en", rs.cpu_en, 0);
    check("rst_count", rs.count_o, 0);
    model_cnt = 0;
    pulses = 0;
    @(posedge clk_i);
    #1 rst = 0;
    cyc(4);
  endtask
  task automatic press(logic r, logic s);
    rs.btn_run = r; rs.btn_step = s;
    cyc(10);
    rs.btn_run = 0; rs.btn_step = 0;
    cyc(10);
  endtask
  task automatic tick(int hi, int lo, bit exp);
    if (exp) begin
      model_cnt = model_cnt + 16'd1;
      q.push_back(model_cnt);
    end
    rs.tick_i = 1;
    cyc(hi);
    rs.tick_i = 0;
    cyc(lo);
  endtask
  initial begin
    forever begin
      @(negedge clk_i);
      if (rs.cpu_en === 1'b1) begin
        pulses++;
        check("cpu_en_width", prev_en, 0);
        if (q.size() == 0) check("unexpected_cpu_en", rs.cpu_en, 0);
        else check("count_o", rs.count_o, q.pop_front());
      end
      prev_en = rs.cpu_en;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, n_bad=%0d", n_bad);
    $fatal(1);
  end
  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 2'b00, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 2'b01, 1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 2'b00, 1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'b01, 1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 2'b11, 0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 2'b11, 0};
    rs.tick_i = 0; rs.btn_run = 0; rs.btn_step = 0; rs.halt_i = 0;
    for (int v = 0; v < 6; v++) begin
      do_reset();
      press(vecs[v].run, vecs[v].step);
      if (vecs[v].halt) begin
        rs.halt_i = 1;
        cyc(1);
        rs.halt_i = 0;
        cyc(2);
      end
      tick(4, 4, vecs[v].exp_pulses != 0);
      cyc(4);
      check($sformatf("vec%0d_state", v), rs.state_o, vecs[v].exp_state);
      check($sformatf("vec%0d_count", v), rs.count_o, vecs[v].exp_pulses);
      check($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
    end
    do_reset();
    press(1, 0);
    for (int t = 0; t < 4; t++) tick(8, 8, 1);
    cyc(4);
    check("run4_state", rs.state_o, 2'b01);
    check("run4_pulses", pulses, 4);
    check("run4_count", rs.count_o, 4);
    do_reset();
    rs.btn_step = 1; cyc(1);
    rs.btn_step = 0; cyc(1);
    rs.btn_step = 1; cyc(12);
    rs.btn_step = 0; cyc(10);
    tick(4, 4, 1);
    for (int t = 0; t < 2; t++) tick(4, 4, 0);
    cyc(4);
    check("bounce_pulses", pulses, 1);
    check("bounce_state", rs.state_o, 2'b00);
    check("bounce_count", rs.count_o, 1);
    do_reset();
    press(1, 0);
    tick(4, 4, 1);
    rs.tick_i = 1;
    cyc(2);
    rs.halt_i = 1;
    cyc(1);
    rs.halt_i = 0;
    cyc(3);
    rs.tick_i = 0;
    cyc(4);
    check("halt_state", rs.state_o, 2'b11);
    check("halt_pulses", pulses, 1);
    press(1, 0);
    press(0, 1);
    tick(4, 4, 0);
    cyc(4);
    check("halted_sticky", rs.state_o, 2'b11);
    check("halted_count", rs.count_o, 1);
    do_reset();
    press(1, 0);
    force rs.count_o = 16'hFFFF;
    cyc(1);
    release rs.count_o;
    model_cnt = 16'hFFFF;
    tick(4, 4, 1);
    cyc(4);
    check("wrap_count", rs.count_o, 16'h0000);
    check("wrap_state", rs.state_o, 2'b01);
    do_reset();
    press(1, 0);
    tick(4, 4, 1);
    check("pre_abort_count", rs.count_o, 1);
    rs.tick_i = 1;
    cyc(2);
    rst = 1;
    rs.btn_run = 1;
    cyc(1);
    @(negedge clk_i);
    check("abort_cpu_en", rs.cpu_en, 0);
    check("abort_state", rs.state_o, 2'b00);
    check("abort_count", rs.count_o, 0);
    model_cnt = 0;
    pulses = 0;
    @(posedge clk_i);
    #1 rst = 0;
    rs.tick_i = 0;
    cyc(20);
    check("held_at_reset", rs.state_o, 2'b00);
    rs.btn_run = 0;
    cyc(10);
    press(1, 0);
    check("repress_state", rs.state_o, 2'b01);
    check("final_queue", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
